branch_target_buffer: RTL and testbench

- Parametrised, direct-mapped branch target buffer with saturating direction counters.
- Lets fetch redirect speculatively instead of waiting for branch/jump resolution in MEM.
- Sits beside the PC:
  - Fetch looks up the current pc combinationally.
  - The MEM stage writes back resolved outcomes.
  - The hazard unit flushes the buffer on context change or halt.
- Generalises the fixed pc4/baddr/jaddr next-PC selection into a predictive, depth-configurable structure.

---
 rtl/branch_target_buffer_pkg.sv | 16 +
 rtl/branch_target_buffer_sat_counter.sv | 25 ++
 rtl/branch_target_buffer.sv | 183 ++++++++++++++++++
 tb/tb_branch_target_buffer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_target_buffer_pkg.sv
// Shared types for the branch target buffer.
// The per-entry layout depends on the top-level parameters, so entries are
// held as parallel arrays in the top module rather than as a fixed struct here.
package branch_target_buffer_pkg;

    // Flush sweep controller states
    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } btb_state_t;

    // Instructions are word aligned; pc bits below this position never
    // take part in indexing or tagging
    localparam int BTB_PC_LSB = 2;

endpackage

// File: rtl/branch_target_buffer_sat_counter.sv
// Combinational next-value logic for an N-bit saturating direction counter.
// force_max has priority and drives the counter straight to all ones.
module sat_counter #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] cur,
    input  logic             inc,
    input  logic             dec,
    input  logic             force_max,
    output logic [WIDTH-1:0] next
);

    // Step up or down by one, holding at the rails instead of wrapping
    always_comb begin
        next = cur;
        if (force_max) begin
            next = '1;
        end else if (inc && !dec && (cur != '1)) begin
            next = cur + 1'b1;
        end else if (dec && !inc && (cur != '0)) begin
            next = cur - 1'b1;
        end
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Fetch looks up lu_pc combinationally; MEM writes resolved outcomes back;
// a flush sweeps the valid bits clear one entry per cycle.
// Optional build macro BTB_STATS_EN adds lookup/update/mispredict counters.
module branch_target_buffer
    import branch_target_buffer_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int WORD_W  = 32,
    parameter int CTR_W   = 2
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [WORD_W-1:0] lu_pc,
    output logic              lu_hit,
    output logic              lu_taken,
    output logic [WORD_W-1:0] lu_target,
    input  logic              up_valid,
    input  logic [WORD_W-1:0] up_pc,
    input  logic              up_taken,
    input  logic              up_jump,
    input  logic [WORD_W-1:0] up_target,
    input  logic              up_mispredict,
    input  logic              flush,
    output logic              busy
`ifdef BTB_STATS_EN
    ,
    output logic [31:0]       stat_lookups,
    output logic [31:0]       stat_updates,
    output logic [31:0]       stat_mispredicts
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = WORD_W - IDX_W - BTB_PC_LSB;
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1 << (CTR_W - 1));
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ENTRIES - 1);

    // Entry storage: only the valid bits need reset, the rest is gated by them
    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [WORD_W-1:0]  target_q [ENTRIES];
    logic [CTR_W-1:0]   ctr_q    [ENTRIES];

    btb_state_t         state_q;
    logic [IDX_W-1:0]   sweep_idx_q;

    logic [IDX_W-1:0]   lu_idx;
    logic [TAG_W-1:0]   lu_tag;
    logic [IDX_W-1:0]   up_idx;
    logic [TAG_W-1:0]   up_tag;
    logic               up_hit;
    logic               up_accept;
    logic               up_redirect;
    logic               up_alloc;
    logic [CTR_W-1:0]   ctr_next;
    logic               unused_bits;

    assign lu_idx = lu_pc[IDX_W+BTB_PC_LSB-1:BTB_PC_LSB];
    assign lu_tag = lu_pc[WORD_W-1:IDX_W+BTB_PC_LSB];
    assign up_idx = up_pc[IDX_W+BTB_PC_LSB-1:BTB_PC_LSB];
    assign up_tag = up_pc[WORD_W-1:IDX_W+BTB_PC_LSB];

`ifdef BTB_STATS_EN
    assign unused_bits = ^{lu_pc[BTB_PC_LSB-1:0], up_pc[BTB_PC_LSB-1:0]};
`else
    assign unused_bits = ^{lu_pc[BTB_PC_LSB-1:0], up_pc[BTB_PC_LSB-1:0], up_mispredict};
`endif

    // Lookup sees pre-edge contents and reports nothing while a sweep is running
    always_comb begin
        lu_hit    = 1'b0;
        lu_taken  = 1'b0;
        lu_target = '0;
        if (!busy && valid_q[lu_idx] && (tag_q[lu_idx] == lu_tag)) begin
            lu_hit    = 1'b1;
            lu_taken  = ctr_q[lu_idx][CTR_W-1];
            lu_target = target_q[lu_idx];
        end
    end

    // Updates are only taken in IDLE and lose to a simultaneous flush
    always_comb begin
        up_accept   = up_valid && (state_q == IDLE) && !flush;
        up_hit      = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        up_redirect = up_taken || up_jump;
        up_alloc    = up_accept && !up_hit && up_redirect;
    end

    sat_counter #(
        .WIDTH     (CTR_W)
    ) u_sat_counter (
        .cur       (ctr_q[up_idx]),
        .inc       (up_taken),
        .dec       (!up_taken),
        .force_max (up_jump),
        .next      (ctr_next)
    );

    // Flush controller: walk every index once, restarting if flush repeats
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            sweep_idx_q <= '0;
            busy        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (flush) begin
                        state_q     <= SWEEP;
                        sweep_idx_q <= '0;
                        busy        <= 1'b1;
                    end
                end
                SWEEP: begin
                    if (flush) begin
                        sweep_idx_q <= '0;
                    end else if (sweep_idx_q == IDX_LAST) begin
                        state_q     <= IDLE;
                        sweep_idx_q <= '0;
                        busy        <= 1'b0;
                    end else begin
                        sweep_idx_q <= sweep_idx_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Valid bits: cleared by the sweep, set when a miss allocates
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q <= '0;
        end else if (state_q == SWEEP) begin
            valid_q[sweep_idx_q] <= 1'b0;
        end else if (up_alloc) begin
            valid_q[up_idx] <= 1'b1;
        end
    end

    // Entry payload: train counters on hits, install fresh entries on taken misses
    always_ff @(posedge CLK) begin
        if (up_accept) begin
            if (up_hit) begin
                ctr_q[up_idx] <= ctr_next;
                if (up_redirect) begin
                    target_q[up_idx] <= up_target;
                end
            end else if (up_redirect) begin
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= up_target;
                ctr_q[up_idx]    <= up_jump ? CTR_MAX : CTR_WEAK;
            end
        end
    end

`ifdef BTB_STATS_EN
    // Activity counters: survive flushes, wrap naturally at 32 bits
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stat_lookups     <= '0;
            stat_updates     <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (!busy) begin
                stat_lookups <= stat_lookups + 32'd1;
            end
            if (up_accept) begin
                stat_updates <= stat_updates + 32'd1;
                if (up_mispredict) begin
                    stat_mispredicts <= stat_mispredicts + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: each stimulus cycle pushes the
// expected lookup response computed from an abstract model; a monitor pops
// and compares on the falling edge.
module tb_branch_target_buffer;

    localparam int ENTRIES = 16;
    localparam int WORD_W  = 32;
    localparam int CTR_W   = 2;
    localparam int CTR_TOP = (1 << CTR_W) - 1;

    logic              CLK;
    logic              nRST;
    logic [WORD_W-1:0] lu_pc;
    logic              lu_hit;
    logic              lu_taken;
    logic [WORD_W-1:0] lu_target;
    logic              up_valid;
    logic [WORD_W-1:0] up_pc;
    logic              up_taken;
    logic              up_jump;
    logic [WORD_W-1:0] up_target;
    logic              up_mispredict;
    logic              flush;
    logic              busy;
`ifdef BTB_STATS_EN
    logic [31:0]       stat_lookups;
    logic [31:0]       stat_updates;
    logic [31:0]       stat_mispredicts;
`endif

    branch_target_buffer #(
        .ENTRIES (ENTRIES),
        .WORD_W  (WORD_W),
        .CTR_W   (CTR_W)
    ) dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .lu_pc         (lu_pc),
        .lu_hit        (lu_hit),
        .lu_taken      (lu_taken),
        .lu_target     (lu_target),
        .up_valid      (up_valid),
        .up_pc         (up_pc),
        .up_taken      (up_taken),
        .up_jump       (up_jump),
        .up_target     (up_target),
        .up_mispredict (up_mispredict),
        .flush         (flush),
        .busy          (busy)
`ifdef BTB_STATS_EN
        ,
        .stat_lookups     (stat_lookups),
        .stat_updates     (stat_updates),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    // Free-running clock, period 10
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        int          cyc;
        logic        hit;
        logic        taken;
        logic [31:0] target;
        logic        busy;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   compared   = 0;
    int   mismatched = 0;
    int   cycle_no   = 0;

    // Reference model: a plain table of entries plus a remaining-busy count
    bit          m_valid  [ENTRIES];
    int unsigned m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_ctr    [ENTRIES];
    int          busy_left = 0;
    int          m_updates = 0;
    int          m_mispredicts = 0;

    task automatic checkOutput(input exp_t e);
        compared++;
        if (lu_hit !== e.hit || lu_taken !== e.taken || lu_target !== e.target || busy !== e.busy) begin
            mismatched++;
            $display("[TB] FAIL lookup@cycle%0d: got hit=%b taken=%b target=%h busy=%b, expected hit=%b taken=%b target=%h busy=%b",
                     e.cyc, lu_hit, lu_taken, lu_target, busy, e.hit, e.taken, e.target, e.busy);
        end
    endtask

    // Drive one cycle of inputs after the edge, record the expected lookup, advance the model
    task automatic applyStimulus(input logic [31:0] pc, input bit uv, input logic [31:0] upc,
                                 input bit tk, input bit jp, input logic [31:0] tgt,
                                 input bit mp, input bit fl);
        exp_t        e;
        int unsigned li;
        int unsigned ui;
        bit          uhit;
        @(posedge CLK);
        #1;
        lu_pc         = pc;
        up_valid      = uv;
        up_pc         = upc;
        up_taken      = tk;
        up_jump       = jp;
        up_target     = tgt;
        up_mispredict = mp;
        flush         = fl;

        li       = (pc / 4) % ENTRIES;
        e.cyc    = cycle_no;
        e.busy   = (busy_left > 0);
        e.hit    = (busy_left == 0) && m_valid[li] && (m_tag[li] == pc / (4 * ENTRIES));
        e.taken  = e.hit && (m_ctr[li] >= (1 << (CTR_W - 1)));
        e.target = e.hit ? m_target[li] : 32'h0;
        exp_q.push_back(e);

        if (uv && busy_left == 0 && !fl) begin
            m_updates++;
            if (mp) m_mispredicts++;
            ui   = (upc / 4) % ENTRIES;
            uhit = m_valid[ui] && (m_tag[ui] == upc / (4 * ENTRIES));
            if (uhit) begin
                if (jp) m_ctr[ui] = CTR_TOP;
                else if (tk) m_ctr[ui] = (m_ctr[ui] == CTR_TOP) ? CTR_TOP : m_ctr[ui] + 1;
                else m_ctr[ui] = (m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1;
                if (tk || jp) m_target[ui] = tgt;
            end else if (tk || jp) begin
                m_valid[ui]  = 1'b1;
                m_tag[ui]    = upc / (4 * ENTRIES);
                m_target[ui] = tgt;
                m_ctr[ui]    = jp ? CTR_TOP : (1 << (CTR_W - 1));
            end
        end
        if (busy_left > 0) busy_left--;
        if (fl) begin
            busy_left = ENTRIES;
            for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
        end
        cycle_no++;
    endtask

    // Monitor: compare the oldest expected response against the DUT mid-cycle
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checkOutput(mon_e);
        end
    end

    initial begin
        logic [31:0] rpc;
        logic [31:0] rupc;
        bit          ruv;
        bit          rfl;
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 0;
        end
        nRST = 1'b0;
        lu_pc = 32'h40;
        up_valid = 1'b0; up_pc = '0; up_taken = 1'b0; up_jump = 1'b0;
        up_target = '0; up_mispredict = 1'b0; flush = 1'b0;

        // Outputs while reset is held
        #12;
        compared++;
        if (lu_hit !== 1'b0 || lu_taken !== 1'b0 || lu_target !== 32'h0 || busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: got hit=%b taken=%b target=%h busy=%b, expected all zero",
                     lu_hit, lu_taken, lu_target, busy);
        end
        #10;
        nRST = 1'b1;

        // Directed: first allocation and lookup
        applyStimulus(32'h40, 0, 32'h0,  0, 0, 32'h0,   0, 0);
        applyStimulus(32'h40, 1, 32'h40, 1, 0, 32'h100, 0, 0);
        applyStimulus(32'h40, 0, 32'h0,  0, 0, 32'h0,   0, 0);
        // Saturation and hysteresis
        for (int i = 0; i < 3; i++) applyStimulus(32'h40, 1, 32'h40, 1, 0, 32'h100, 1, 0);
        for (int i = 0; i < 3; i++) applyStimulus(32'h40, 1, 32'h40, 0, 0, 32'h0,   0, 0);
        applyStimulus(32'h40, 1, 32'h40, 1, 0, 32'h104, 0, 0);
        applyStimulus(32'h40, 0, 32'h0,  0, 0, 32'h0,   0, 0);
        // Aliasing at index 0
        applyStimulus(32'h80, 1, 32'h80, 1, 0, 32'h200, 0, 0);
        applyStimulus(32'h40, 0, 32'h0,  0, 0, 32'h0,   0, 0);
        applyStimulus(32'h80, 1, 32'hC0, 0, 0, 32'h300, 0, 0);
        applyStimulus(32'hC0, 0, 32'h0,  0, 0, 32'h0,   0, 0);
        // Flush colliding with a taken update, then the full sweep
        applyStimulus(32'h80, 1, 32'h204, 1, 0, 32'h500, 0, 1);
        for (int i = 0; i < ENTRIES + 2; i++) applyStimulus((i % 2) ? 32'h80 : 32'h204, 0, 32'h0, 0, 0, 32'h0, 0, 0);
        // Same-cycle lookup and update from counter 1 to 2
        applyStimulus(32'h40, 1, 32'h40, 1, 0, 32'h140, 0, 0);
        applyStimulus(32'h40, 1, 32'h40, 0, 0, 32'h0,   0, 0);
        applyStimulus(32'h40, 1, 32'h40, 1, 0, 32'h144, 0, 0);
        applyStimulus(32'h40, 0, 32'h0,  0, 0, 32'h0,   0, 0);
        // Jump allocates straight to max
        applyStimulus(32'h44, 1, 32'h44, 0, 1, 32'h600, 0, 0);
        applyStimulus(32'h44, 1, 32'h44, 0, 0, 32'h0,   0, 0);
        applyStimulus(32'h44, 0, 32'h0,  0, 0, 32'h0,   0, 0);

        // Randomized traffic over a small pc window to force hits and aliases
        for (int n = 0; n < 1500; n++) begin
            rpc  = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            rupc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            ruv  = ($urandom_range(0, 1) == 1);
            rfl  = ($urandom_range(0, 79) == 0);
            applyStimulus(rpc, ruv, rupc, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                          $urandom, $urandom_range(0, 1) == 1, rfl);
        end
        applyStimulus(32'h0, 0, 32'h0, 0, 0, 32'h0, 0, 0);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(negedge CLK);
        #1;
        if (exp_q.size() > 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain: %0d responses left unchecked, expected 0", exp_q.size());
        end

`ifdef BTB_STATS_EN
        @(posedge CLK);
        #1;
        compared++;
        if (stat_updates !== 32'(m_updates) || stat_mispredicts !== 32'(m_mispredicts)) begin
            mismatched++;
            $display("[TB] FAIL stats: got updates=%0d mispredicts=%0d, expected updates=%0d mispredicts=%0d",
                     stat_updates, stat_mispredicts, m_updates, m_mispredicts);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
